// File: rtl/delay_calibrator.sv
// delay_calibrator: measures the speaker-to-microphone round-trip delay in
// audio samples. Emits a silent settle period, then a click burst, and counts
// samples (from the first click sample) until |mic_in| crosses THRESHOLD.
// Optional build macro DELAY_CAL_AVG_EN: run four passes per start and report
// the truncated mean of the four detected delays.
module delay_calibrator #(
  parameter int unsigned MAX_DELAY      = 48000,
  parameter int unsigned CLICK_LEN      = 48,
  parameter logic [15:0] CLICK_AMP      = 16'h6000,
  parameter logic [15:0] THRESHOLD      = 16'd8000,
  parameter int unsigned SETTLE_SAMPLES = 4800
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        audio_valid_in,
  input  logic [15:0] mic_in,
  output logic [15:0] click_out,
  output logic        click_valid_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        timeout_out,
  output logic [15:0] delay_cycle_out,
  output logic [15:0] peak_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_EMIT   = 3'd2,
    S_LISTEN = 3'd3,
    S_REPORT = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_SAMPLES - 1);
  localparam logic [15:0] CLICK_LAST  = 16'(CLICK_LEN - 1);
  localparam logic [15:0] K_LAST      = 16'(MAX_DELAY - 1);

  // Saturating absolute value: the most negative sample folds to 32767.
  function automatic logic [15:0] abs_sat(input logic [15:0] x);
    logic [15:0] r;
    if (x == 16'h8000) begin
      r = 16'h7FFF;
    end else if (x[15]) begin
      r = ~x + 16'd1;
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;       // settle strobe counter
  logic [15:0] k_q, k_d;           // sample index since first click sample
  logic [15:0] click_q, click_d;
  logic        click_vld_q, click_vld_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic [15:0] delay_q, delay_d;
  logic [15:0] peak_q, peak_d;
`ifdef DELAY_CAL_AVG_EN
  logic [1:0]  pass_q, pass_d;
  logic [17:0] sum_q, sum_d;
  logic [17:0] sum_tot_s;
`endif

  logic [15:0] mag_s;
  logic        hit_s;

  assign mag_s = abs_sat(mic_in);
  assign hit_s = audio_valid_in && (mag_s >= THRESHOLD);
`ifdef DELAY_CAL_AVG_EN
  assign sum_tot_s = sum_q + {2'b00, k_q};
`endif

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      k_q         <= 16'd0;
      click_q     <= 16'd0;
      click_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      delay_q     <= 16'd0;
      peak_q      <= 16'd0;
`ifdef DELAY_CAL_AVG_EN
      pass_q      <= 2'd0;
      sum_q       <= 18'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      click_q     <= click_d;
      click_vld_q <= click_vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      delay_q     <= delay_d;
      peak_q      <= peak_d;
`ifdef DELAY_CAL_AVG_EN
      pass_q      <= pass_d;
      sum_q       <= sum_d;
`endif
    end
  end

  // Next-state logic; detection outranks timeout on the same sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (audio_valid_in && (cnt_q == SETTLE_LAST)) begin
          state_d = S_EMIT;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_EMIT, S_LISTEN: begin
        if (hit_s) begin
`ifdef DELAY_CAL_AVG_EN
          state_d = (pass_q == 2'd3) ? S_REPORT : S_SETTLE;
`else
          state_d = S_REPORT;
`endif
        end else if (audio_valid_in && (k_q == K_LAST)) begin
          state_d = S_FAIL;
        end else if (audio_valid_in && (state_q == S_EMIT) && (k_q == CLICK_LAST)) begin
          state_d = S_LISTEN;
        end else begin
          state_d = state_q;
        end
      end
      S_REPORT: state_d = S_IDLE;
      S_FAIL:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d       = cnt_q;
    k_d         = k_q;
    click_d     = click_q;
    click_vld_d = 1'b0;
    delay_d     = delay_q;
    peak_d      = peak_q;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_REPORT);
    tmo_d       = (state_d == S_FAIL);
`ifdef DELAY_CAL_AVG_EN
    pass_d      = pass_q;
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        click_d = 16'd0;
        if (start_in) begin
          cnt_d  = 16'd0;
          k_d    = 16'd0;
          peak_d = 16'd0;
`ifdef DELAY_CAL_AVG_EN
          pass_d = 2'd0;
          sum_d  = 18'd0;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_SETTLE: begin
        if (audio_valid_in) begin
          click_d     = 16'd0;
          click_vld_d = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          k_d         = 16'd0;
        end else begin
          click_vld_d = 1'b0;
        end
      end
      S_EMIT, S_LISTEN: begin
        if (audio_valid_in) begin
          peak_d = (mag_s > peak_q) ? mag_s : peak_q;
          if (hit_s) begin
            click_d     = 16'd0;
            click_vld_d = 1'b0;
`ifdef DELAY_CAL_AVG_EN
            if (pass_q == 2'd3) begin
              delay_d = sum_tot_s[17:2];
            end else begin
              sum_d  = sum_tot_s;
              pass_d = pass_q + 2'd1;
              cnt_d  = 16'd0;
              k_d    = 16'd0;
            end
`else
            delay_d = k_q;
`endif
          end else if (k_q == K_LAST) begin
            click_d     = 16'd0;
            click_vld_d = 1'b0;
          end else begin
            click_d     = (state_q == S_EMIT) ? CLICK_AMP : 16'd0;
            click_vld_d = 1'b1;
            k_d         = k_q + 16'd1;
          end
        end else begin
          click_vld_d = 1'b0;
        end
      end
      S_REPORT, S_FAIL: begin
        click_d = 16'd0;
      end
      default: begin
        click_d = 16'd0;
      end
    endcase
  end

  assign click_out       = click_q;
  assign click_valid_out = click_vld_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign timeout_out     = tmo_q;
  assign delay_cycle_out = delay_q;
  assign peak_out        = peak_q;

endmodule

// File: tb/tb_delay_calibrator.sv
// Self-checking bench for delay_calibrator: loopback of click_out to mic_in,
// timeout, saturation, start/reset handling; averaging runs when
// DELAY_CAL_AVG_EN is defined.
module tb_delay_calibrator;

  localparam int MAXD   = 1500;
  localparam int CLEN   = 48;
  localparam int SETTLE = 64;
`ifdef DELAY_CAL_AVG_EN
  localparam int NPASS  = 4;
`else
  localparam int NPASS  = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, av;
  logic [15:0] mic;
  logic [15:0] click_out, delay, peak;
  logic        click_vld, busy, done, tmo;

  always #5 clk = ~clk;

  delay_calibrator #(
    .MAX_DELAY(MAXD), .CLICK_LEN(CLEN), .CLICK_AMP(16'h6000),
    .THRESHOLD(16'd8000), .SETTLE_SAMPLES(SETTLE)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .audio_valid_in(av),
    .mic_in(mic), .click_out(click_out), .click_valid_out(click_vld),
    .busy_out(busy), .done_out(done), .timeout_out(tmo),
    .delay_cycle_out(delay), .peak_out(peak)
  );

  typedef struct packed {
    logic        is_done;
    logic [15:0] dly;
    logic [15:0] pk;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] hist[$];
  int          pass_d[4];
  int          n_vec = 0, n_miss = 0, n_done = 0, n_tmo = 0;
  bit          got_pulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record clicks for the loopback and score any done/timeout pulse.
  task automatic observe();
    exp_t e;
    if (click_vld) hist.push_back(click_out);
    if (done || tmo) begin
      got_pulse = 1'b1;
      if (done) n_done++;
      if (tmo)  n_tmo++;
      if (exp_q.size() == 0) begin
        chk("stray_pulse", {30'd0, done, tmo}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done", done, e.is_done);
        chk("timeout", tmo, !e.is_done);
        chk("delay", delay, e.dly);
        chk("peak", peak, e.pk);
        chk("busy_at_pulse", busy, 1);
      end
    end
  endtask

  // mode 0: loopback with per-pass delay pass_d; 1: silence; 2: saturation.
  task automatic run_meas(input int mode, input int exp_strobes, input int restart_at);
    int n, pass, strobes, dd;
    logic [15:0] v;
    got_pulse = 1'b0;
    hist.delete();
    n = 0; pass = 0; strobes = 0;
    start = 1'b1; tick(); start = 1'b0; observe();
    chk("busy_on_start", busy, 1);
    while (!got_pulse && strobes < exp_strobes + 8) begin
      dd = (mode == 0) ? pass_d[pass] : (mode == 2) ? 0 : 99999;
      case (mode)
        0: v = (dd > 0 && hist.size() >= dd) ? hist[hist.size() - dd] : 16'h0000;
        2: v = (n < SETTLE) ? 16'd9000 : ((n == SETTLE) ? 16'h8000 : 16'h0000);
        default: v = 16'h0000;
      endcase
      av = 1'b1; mic = v; tick(); av = 1'b0; mic = 16'h0000;
      strobes++; n++;
      observe();
      if (got_pulse) break;
      if (n == SETTLE + dd + 1 && pass < NPASS - 1) begin
        pass++; n = 0; hist.delete();
      end
      for (int i = 0; i < 3; i++) begin
        if (strobes == restart_at && i == 0) start = 1'b1;
        tick(); start = 1'b0; observe();
      end
    end
    chk("pulse_seen", got_pulse, 1);
    chk("strobe_count", strobes, exp_strobes);
    tick(); observe();
    chk("busy_after_pulse", busy, 0);
    chk("done_after_pulse", done, 0);
    chk("click_zero_after", click_out, 16'h0000);
  endtask

  task automatic quiet_window(input int nstrobes);
    hist.delete();
    for (int i = 0; i < nstrobes; i++) begin
      av = 1'b1; tick(); av = 1'b0; observe();
      tick(); observe();
    end
    chk("quiet_clicks", hist.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b1; av = 1'b0; mic = 16'h0000;
    // Reset, with start held during it.
    repeat (3) tick();
    chk("rst_click", click_out, 0);
    chk("rst_click_vld", click_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_delay", delay, 0);
    chk("rst_peak", peak, 0);
    start = 1'b0; rst_n = 1'b1;
    repeat (4) begin tick(); observe(); end
    chk("start_in_reset_ignored", busy, 0);

    // Loopback 1234 with a stray start during LISTEN.
    for (int i = 0; i < 4; i++) pass_d[i] = 1234;
    exp_q.push_back('{is_done: 1'b1, dly: 16'd1234, pk: 16'h6000});
    run_meas(0, NPASS * (SETTLE + 1235), SETTLE + CLEN + 10);
    quiet_window(10);

    // Timeout: silence throughout, delay keeps 1234.
    exp_q.push_back('{is_done: 1'b0, dly: 16'd1234, pk: 16'h0000});
    run_meas(1, SETTLE + MAXD, -1);
    quiet_window(5);

    // Reset in the middle of LISTEN.
    start = 1'b1; tick(); start = 1'b0; observe();
    for (int i = 0; i < SETTLE + CLEN + 20; i++) begin
      av = 1'b1; tick(); av = 1'b0; observe();
      tick(); observe();
    end
    chk("busy_mid_listen", busy, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mr_click", click_out, 0);
    chk("mr_click_vld", click_vld, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_tmo", tmo, 0);
    chk("mr_delay", delay, 0);
    chk("mr_peak", peak, 0);
    quiet_window(10);

    // Saturated sample on the first EMIT sample; loud settle must be ignored.
    exp_q.push_back('{is_done: 1'b1, dly: 16'd0, pk: 16'h7FFF});
    run_meas(2, NPASS * (SETTLE + 1), -1);

`ifdef DELAY_CAL_AVG_EN
    pass_d[0] = 100; pass_d[1] = 101; pass_d[2] = 102; pass_d[3] = 103;
    exp_q.push_back('{is_done: 1'b1, dly: 16'd101, pk: 16'h6000});
    run_meas(0, 4 * SETTLE + 406 + 4, -1);
    pass_d[0] = 100; pass_d[1] = 101; pass_d[2] = 99999; pass_d[3] = 0;
    exp_q.push_back('{is_done: 1'b0, dly: 16'd101, pk: 16'h6000});
    run_meas(0, 3 * SETTLE + 101 + 102 + MAXD, -1);
    chk("done_total", n_done, 3);
    chk("timeout_total", n_tmo, 2);
`else
    chk("done_total", n_done, 2);
    chk("timeout_total", n_tmo, 1);
`endif
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
